// File: rtl/edge_run_length_if.sv
// edge_run_length_if
//   Beat bus for edge_run_length: upstream pixel-pair beats with valid/ready,
//   downstream per-channel distance/edge beats with valid/ready.
//   slave  : block side (edge_run_length)
//   master : driver side (window buffer / cost aggregation / testbench)
//   Signals: i_valid/o_ready/i_sol/i_pix_a/i_pix_b/i_beta/i_mode (upstream),
//            o_valid/i_ready/o_dist/o_edge (downstream). Directions are named
//            from the block's point of view.
interface edge_run_length_if #(
  parameter int NCH = 2,
  parameter int DW  = 8,
  parameter int CW  = 8
);
  logic              i_valid;
  logic              o_ready;
  logic              i_sol;
  logic [NCH*DW-1:0] i_pix_a;
  logic [NCH*DW-1:0] i_pix_b;
  logic [DW-1:0]     i_beta;
  logic              i_mode;
  logic              o_valid;
  logic              i_ready;
  logic [NCH*CW-1:0] o_dist;
  logic [NCH-1:0]    o_edge;

  modport slave (
    input  i_valid, i_sol, i_pix_a, i_pix_b, i_beta, i_mode, i_ready,
    output o_ready, o_valid, o_dist, o_edge
  );

  modport master (
    output i_valid, i_sol, i_pix_a, i_pix_b, i_beta, i_mode, i_ready,
    input  o_ready, o_valid, o_dist, o_edge
  );
endinterface

// File: rtl/edge_run_length.sv
// edge_run_length
//   Multi-channel distance-since-last-edge tracker. Each channel compares a
//   reference pixel against its neighbour with a runtime threshold; the output
//   is a saturating count of beats since that channel's last edge.
//   Two-stage valid/ready pipeline: S1 holds edge flags + sol, S2 is the
//   output register and also the per-channel counter state.
//   Ports:
//     i_clk  : clock, rising edge
//     i_rst  : asynchronous active-high reset
//     bus    : edge_run_length_if.slave (beat handshake, pixels, threshold,
//              mode, distance/edge outputs)

// Per-channel slice: edge detect at accept, distance update on S1->S2 move.
module erl_lane #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [DW-1:0] i_beta,
  input  logic          i_mode,
  input  logic          i_acc,
  input  logic          i_move,
  input  logic          i_sol1,
  output logic [CW-1:0] o_dist,
  output logic          o_edge
);
  logic [DW-1:0] w_diff;
  logic          w_edge;
  logic [CW-1:0] w_prev;
  logic [CW-1:0] w_next;
  logic          r_edge1;
  logic [CW-1:0] r_dist;
  logic          r_edge2;

  // magnitude difference, never wraps
  assign w_diff = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
  assign w_edge = i_mode ? ((i_a > i_b) && (w_diff > i_beta)) : (w_diff > i_beta);

  assign w_prev = i_sol1 ? '0 : r_dist;
  assign w_next = r_edge1 ? '0 : ((&w_prev) ? w_prev : w_prev + 1'b1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_edge1 <= 1'b0;
      r_dist  <= '0;
      r_edge2 <= 1'b0;
    end else begin
      if (i_acc)  r_edge1 <= w_edge;
      if (i_move) begin
        r_dist  <= w_next;
        r_edge2 <= r_edge1;
      end
    end
  end

  assign o_dist = r_dist;
  assign o_edge = r_edge2;
endmodule

module edge_run_length #(
  parameter int NCH = 2,
  parameter int DW  = 8,
  parameter int CW  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  edge_run_length_if.slave bus
);
  localparam int STAGES = 2;

  logic [STAGES:1]          r_vld_pipe;   // [1] = S1 full, [2] = S2 / o_valid
  logic                     r_sol1;
  logic                     w_s2_adv;
  logic                     w_move;
  logic                     w_acc;
  logic [NCH-1:0][DW-1:0]   w_a;
  logic [NCH-1:0][DW-1:0]   w_b;
  logic [NCH-1:0][CW-1:0]   w_dist;
  logic [NCH-1:0]           w_edge;

  assign w_s2_adv    = !r_vld_pipe[2] || bus.i_ready;
  assign w_move      = r_vld_pipe[1] && w_s2_adv;
  assign bus.o_ready = !r_vld_pipe[1] || w_s2_adv;
  assign w_acc       = bus.i_valid && bus.o_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld_pipe <= '0;
      r_sol1     <= 1'b0;
    end else begin
      // S1 refills in the same cycle it drains when a new beat is accepted
      if (w_acc)       r_vld_pipe[1] <= 1'b1;
      else if (w_move) r_vld_pipe[1] <= 1'b0;
      if (w_move)             r_vld_pipe[2] <= 1'b1;
      else if (bus.i_ready)   r_vld_pipe[2] <= 1'b0;
      if (w_acc) r_sol1 <= bus.i_sol;
    end
  end

  assign w_a = bus.i_pix_a;
  assign w_b = bus.i_pix_b;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    erl_lane #(.DW(DW), .CW(CW)) u_lane (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_a    (w_a[c]),
      .i_b    (w_b[c]),
      .i_beta (bus.i_beta),
      .i_mode (bus.i_mode),
      .i_acc  (w_acc),
      .i_move (w_move),
      .i_sol1 (r_sol1),
      .o_dist (w_dist[c]),
      .o_edge (w_edge[c])
    );
  end

  assign bus.o_valid = r_vld_pipe[2];
  assign bus.o_dist  = w_dist;
  assign bus.o_edge  = w_edge;
endmodule

// File: tb/tb_edge_run_length.sv
module tb_edge_run_length;
  localparam int NCH = 2, DW = 8, CW = 4, MAXD = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  edge_run_length_if #(.NCH(NCH), .DW(DW), .CW(CW)) vif ();
  edge_run_length #(.NCH(NCH), .DW(DW), .CW(CW)) dut (.i_clk(clk), .i_rst(rst), .bus(vif));

  typedef struct {
    logic       sol, mode;
    logic [7:0] beta, a0, b0, a1, b1;
    int         d0, e0, d1, e1;
  } vec_t;
  typedef struct { int d[NCH]; int e[NCH]; } exp_t;

  vec_t tbl [0:63];
  int   nv = 0;
  exp_t mq[$], tq[$];
  int   last[NCH];
  bit   stall_p = 0;
  logic [NCH*CW-1:0] hd;
  logic [NCH-1:0]    he;
  int   n_cmp = 0, n_err = 0;
  bit   done = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic sol, mode, input logic [7:0] beta, a0, b0, a1, b1,
                     input int d0, e0, d1, e1);
    exp_t x;
    tbl[nv] = '{sol, mode, beta, a0, b0, a1, b1, d0, e0, d1, e1};
    x.d[0] = d0; x.e[0] = e0; x.d[1] = d1; x.e[1] = e1;
    tq.push_back(x);
    nv++;
  endtask

  // Stream-level reference: strict threshold on the true difference.
  function automatic int mdl_edge(int a, int b, int beta, int mode);
    int d = a - b;
    if (mode != 0) return (d > beta) ? 1 : 0;
    return (((d < 0) ? -d : d) > beta) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    bit acc, xfr;
    exp_t e, t;
    int pa, pb, prev;
    if (rst) begin
      mq.delete(); tq.delete();
      for (int c = 0; c < NCH; c++) last[c] = 0;
      stall_p = 0;
    end else begin
      acc = vif.i_valid && vif.o_ready;
      xfr = vif.o_valid && vif.i_ready;
      chk("o_ready", vif.o_ready, !(mq.size() == 2 && !vif.i_ready));
      if (stall_p) begin
        chk("stall_valid", vif.o_valid, 1);
        chk("stall_dist", vif.o_dist, hd);
        chk("stall_edge", vif.o_edge, he);
      end
      if (xfr) begin
        chk("beat_expected", mq.size() > 0, 1);
        if (mq.size() > 0) begin
          e = mq.pop_front();
          for (int c = 0; c < NCH; c++) begin
            chk($sformatf("mdl_dist%0d", c), vif.o_dist[c*CW +: CW], e.d[c]);
            chk($sformatf("mdl_edge%0d", c), vif.o_edge[c], e.e[c]);
          end
        end
        if (tq.size() > 0) begin
          t = tq.pop_front();
          for (int c = 0; c < NCH; c++) begin
            chk($sformatf("tbl_dist%0d", c), vif.o_dist[c*CW +: CW], t.d[c]);
            chk($sformatf("tbl_edge%0d", c), vif.o_edge[c], t.e[c]);
          end
        end
      end
      if (acc) begin
        for (int c = 0; c < NCH; c++) begin
          pa = int'(vif.i_pix_a[c*DW +: DW]);
          pb = int'(vif.i_pix_b[c*DW +: DW]);
          e.e[c] = mdl_edge(pa, pb, int'(vif.i_beta), int'(vif.i_mode));
          prev = vif.i_sol ? 0 : last[c];
          e.d[c] = e.e[c] ? 0 : ((prev + 1 > MAXD) ? MAXD : prev + 1);
          last[c] = e.d[c];
        end
        mq.push_back(e);
      end
      stall_p = vif.o_valid && !vif.i_ready;
      hd = vif.o_dist;
      he = vif.o_edge;
    end
  end

  task automatic send(input logic sol, mode, input logic [7:0] beta, a0, b0, a1, b1);
    bit got = 0;
    vif.i_sol = sol; vif.i_mode = mode; vif.i_beta = beta;
    vif.i_pix_a = {a1, a0}; vif.i_pix_b = {b1, b0};
    vif.i_valid = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk); got = vif.o_ready;
      @(posedge clk); #1;
    end
    chk("send_accept", got, 1);
  endtask

  task automatic drain(input string nm);
    vif.i_valid = 1'b0;
    vif.i_ready = 1'b1;
    for (int k = 0; k < 50 && (mq.size() != 0 || vif.o_valid); k++) @(posedge clk);
    #1;
    chk(nm, mq.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ra, rb, ra1, rb1;
    vif.i_valid = 0; vif.i_sol = 0; vif.i_mode = 0; vif.i_beta = 0;
    vif.i_pix_a = '0; vif.i_pix_b = '0; vif.i_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", vif.o_valid, 0);
    chk("rst_dist", vif.o_dist, 0);
    chk("rst_edge", vif.o_edge, 0);
    chk("rst_ready", vif.o_ready, 1);
    rst = 0;
    @(posedge clk); #1;
    chk("post_rst_ready", vif.o_ready, 1);

    // directed table
    add(1, 0, 40, 100, 50, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 10; i++) add(0, 0, 40, 100, 100, 0, 0, i, 0, i + 1, 0);
    add(0, 0, 40, 90, 50, 0, 0, 11, 0, 12, 0);   // equality: no edge
    add(0, 0, 40, 91, 50, 0, 0, 0, 1, 13, 0);
    add(0, 1, 40, 50, 100, 0, 0, 1, 0, 14, 0);   // rising-only ignores falling
    add(0, 0, 40, 50, 100, 0, 0, 0, 1, 15, 0);
    for (int i = 1; i <= 20; i++) add(0, 0, 40, 100, 100, 0, 0, (i > MAXD) ? MAXD : i, 0, MAXD, 0);
    add(0, 0, 40, 100, 50, 200, 10, 0, 1, 0, 1);
    for (int i = 1; i <= 7; i++) add(0, 0, 40, 100, 100, 0, 0, i, 0, i, 0);
    add(1, 0, 40, 100, 100, 0, 0, 1, 0, 1, 0);   // sol restart, no edge
    add(1, 0, 40, 100, 50, 0, 0, 0, 1, 1, 0);    // sol with edge

    for (int i = 0; i < nv; i++) begin
      send(tbl[i].sol, tbl[i].mode, tbl[i].beta, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1);
      if (i == 0) chk("lat_t1_valid", vif.o_valid, 0);
      if (i == 1) begin
        chk("lat_t2_valid", vif.o_valid, 1);
        chk("lat_t2_dist0", vif.o_dist[CW-1:0], 0);
        chk("lat_t2_edge0", vif.o_edge[0], 1);
      end
    end
    drain("tbl_drain");
    chk("tbl_left", tq.size(), 0);

    // random back-pressure and gaps
    fork
      begin
        while (!done) begin
          @(posedge clk); #1;
          vif.i_ready = $urandom_range(0, 1);
        end
      end
      begin
        for (int n = 0; n < 1000; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            vif.i_valid = 0;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          end
          ra  = $urandom; rb  = ra + 8'($urandom_range(0, 60)) - 8'd30;
          ra1 = $urandom; rb1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ra1;
          send($urandom_range(0, 29) == 0, $urandom_range(0, 1), 8'($urandom_range(20, 50)),
               ra, rb, ra1, rb1);
        end
        vif.i_valid = 0;
        done = 1;
      end
    join
    drain("rnd_drain");

    // reset while stalled with both stages full
    vif.i_ready = 0;
    send(0, 0, 40, 100, 100, 0, 0);
    send(0, 0, 40, 100, 100, 0, 0);
    vif.i_valid = 0;
    chk("stall_full_valid", vif.o_valid, 1);
    chk("stall_full_ready", vif.o_ready, 0);
    #2 rst = 1;
    #1;
    chk("midrst_valid", vif.o_valid, 0);
    chk("midrst_dist", vif.o_dist, 0);
    chk("midrst_edge", vif.o_edge, 0);
    chk("midrst_ready", vif.o_ready, 1);
    @(posedge clk); #1 rst = 0;
    vif.i_ready = 1;
    add(0, 0, 40, 100, 100, 0, 0, 1, 0, 1, 0);
    send(0, 0, 40, 100, 100, 0, 0);
    drain("rst_drain");
    chk("rst_tbl_left", tq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
